// File: rtl/mult_share_ctrl_if.sv
// Requester and multiplier-side signals of the two-port multiplier share controller.
interface mult_share_ctrl_if #(
  parameter int W = 24
);
  logic             req0;
  logic             req1;
  logic [W-1:0]     a0;
  logic [W-1:0]     b0;
  logic [W-1:0]     a1;
  logic [W-1:0]     b1;
  logic             gnt0;
  logic             gnt1;
  logic             done0;
  logic             done1;
  logic [2*W-1:0]   result;
  logic             err;
  logic             busy;
  logic             mult_start;
  logic [W-1:0]     mult_a;
  logic [W-1:0]     mult_b;
  logic [2*W-1:0]   mult_result;
  logic             mult_ready;

  modport master (
    input  req0, req1, a0, b0, a1, b1, mult_result, mult_ready,
    output gnt0, gnt1, done0, done1, result, err, busy, mult_start, mult_a, mult_b
  );

  modport slave (
    output req0, req1, a0, b0, a1, b1, mult_result, mult_ready,
    input  gnt0, gnt1, done0, done1, result, err, busy, mult_start, mult_a, mult_b
  );
endinterface

// File: rtl/mult_share_ctrl.sv
// Round-robin arbiter sharing one sequential multiplier between two requesters; gnt 1 cycle after req,
// done >= 3 cycles after gnt (TIMEOUT cycles worst case); requests are held off without grant while busy.
module mult_share_ctrl #(
  parameter int W       = 24,
  parameter int TIMEOUT = 255
) (
  input logic               clk,
  input logic               rst,
  mult_share_ctrl_if.master bus
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, BUSY, WAIT, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          sel;
  logic          last;
  logic          pick;
  logic          timeout;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;

  // last = requester served most recently; a tie goes to the other one
  assign pick    = (bus.req0 && bus.req1) ? ~last : bus.req1;
  assign op_a    = pick ? bus.a1 : bus.a0;
  assign op_b    = pick ? bus.b1 : bus.b0;
  assign timeout = (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      cnt            <= '0;
      sel            <= 1'b0;
      last           <= 1'b1;
      bus.gnt0       <= 1'b0;
      bus.gnt1       <= 1'b0;
      bus.done0      <= 1'b0;
      bus.done1      <= 1'b0;
      bus.err        <= 1'b0;
      bus.busy       <= 1'b0;
      bus.mult_start <= 1'b0;
      bus.result     <= '0;
      bus.mult_a     <= '0;
      bus.mult_b     <= '0;
    end else begin
      bus.gnt0       <= 1'b0;
      bus.gnt1       <= 1'b0;
      bus.done0      <= 1'b0;
      bus.done1      <= 1'b0;
      bus.err        <= 1'b0;
      bus.mult_start <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            state          <= ISSUE;
            sel            <= pick;
            last           <= pick;
            bus.gnt0       <= ~pick;
            bus.gnt1       <= pick;
            bus.mult_start <= 1'b1;
            bus.mult_a     <= op_a;
            bus.mult_b     <= op_b;
            bus.busy       <= 1'b1;
            cnt            <= '0;
          end
        end
        ISSUE: begin
          state <= BUSY;
          // cnt holds the number of cycles elapsed since ISSUE
          cnt   <= CW'(1);
        end
        BUSY, WAIT: begin
          if (state == WAIT && bus.mult_ready) begin
            state      <= DONE;
            bus.result <= bus.mult_result;
            bus.done0  <= ~sel;
            bus.done1  <= sel;
          end else if (timeout) begin
            state      <= DONE;
            bus.result <= '0;
            bus.err    <= 1'b1;
            bus.done0  <= ~sel;
            bus.done1  <= sel;
          end else begin
            cnt <= cnt + 1'b1;
            if (state == BUSY && !bus.mult_ready) begin
              state <= WAIT;
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mult_share_ctrl.sv
// Randomized bench for mult_share_ctrl: behavioural multiplier plus a transaction-level
// model of arbitration order, completion time, product and timeout.
module tb_mult_share_ctrl;
  localparam int W       = 24;
  localparam int TIMEOUT = 255;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  mult_share_ctrl_if #(.W(W)) bus ();

  mult_share_ctrl #(.W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural multiplier: ready low for lat cycles after start, then product; stuck keeps ready high.
  logic           mready = 1'b1;
  logic [2*W-1:0] mres = '0;
  logic [2*W-1:0] mpend = '0;
  int             mcnt = 0;
  int             lat = 4;
  bit             stuck = 1'b0;
  bit             rr_last = 1'b1;

  assign bus.mult_ready  = mready;
  assign bus.mult_result = mres;

  always @(posedge clk) begin
    if (bus.mult_start && !stuck) begin
      mready <= 1'b0;
      mcnt   <= lat;
      mpend  <= (2*W)'(bus.mult_a) * (2*W)'(bus.mult_b);
      mres   <= '1;
    end else if (!mready) begin
      if (mcnt <= 1) begin
        mready <= 1'b1;
        mres   <= mpend;
      end else begin
        mcnt <= mcnt - 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst && (bus.gnt0 || bus.gnt1 || bus.done0 || bus.done1 || bus.mult_start || bus.err)) begin
      chk("gnt_excl", 64'(bus.gnt0 & bus.gnt1), 64'(0));
      chk("done_excl", 64'(bus.done0 & bus.done1), 64'(0));
      chk("start_with_gnt", 64'(bus.mult_start), 64'(bus.gnt0 | bus.gnt1));
      chk("err_with_done", 64'(bus.err & ~(bus.done0 | bus.done1)), 64'(0));
    end
  end

  task automatic chk_rst_vals();
    chk("rst_gnt0", 64'(bus.gnt0), 64'(0));
    chk("rst_gnt1", 64'(bus.gnt1), 64'(0));
    chk("rst_done0", 64'(bus.done0), 64'(0));
    chk("rst_done1", 64'(bus.done1), 64'(0));
    chk("rst_err", 64'(bus.err), 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_start", 64'(bus.mult_start), 64'(0));
    chk("rst_result", 64'(bus.result), 64'(0));
    chk("rst_mult_a", 64'(bus.mult_a), 64'(0));
    chk("rst_mult_b", 64'(bus.mult_b), 64'(0));
  endtask

  task automatic wait_gnt(output int who, output int at);
    who = -1;
    at  = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.gnt0 || bus.gnt1) begin
        who = bus.gnt1 ? 1 : 0;
        at  = cyc;
        break;
      end
    end
  endtask

  task automatic wait_done(output int who, output int at);
    who = -1;
    at  = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.done0 || bus.done1) begin
        who = bus.done1 ? 1 : 0;
        at  = cyc;
        break;
      end
    end
  endtask

  task automatic wait_mult_idle();
    for (int i = 0; i < 400 && !mready; i++) @(negedge clk);
    chk("mult_idle", 64'(mready), 64'(1));
  endtask

  // Raise the given requests, then follow every expected grant through to its done pulse.
  task automatic do_round(input bit r0, input bit r1, input int lat_i, input bit stuck_i);
    int             order[2];
    int             n;
    int             who;
    int             at;
    int             dwho;
    int             dat;
    int             prev;
    int             off;
    bit             eerr;
    logic [W-1:0]   ea;
    logic [W-1:0]   eb;
    logic [2*W-1:0] eres;
    if (r0 && r1) begin
      order[0] = rr_last ? 0 : 1;
      order[1] = 1 - order[0];
      n = 2;
    end else begin
      order[0] = r1 ? 1 : 0;
      order[1] = 0;
      n = 1;
    end
    wait_mult_idle();
    @(negedge clk);
    lat      = lat_i;
    stuck    = stuck_i;
    bus.req0 = r0;
    bus.req1 = r1;
    prev     = cyc;
    for (int k = 0; k < n; k++) begin
      wait_gnt(who, at);
      chk("gnt_who", 64'(who), 64'(order[k]));
      chk("gnt_cyc", 64'(at), 64'(prev + ((k == 0) ? 1 : 2)));
      ea = order[k] ? bus.a1 : bus.a0;
      eb = order[k] ? bus.b1 : bus.b0;
      chk("issue_start", 64'(bus.mult_start), 64'(1));
      chk("issue_mult_a", 64'(bus.mult_a), 64'(ea));
      chk("issue_mult_b", 64'(bus.mult_b), 64'(eb));
      rr_last = order[k][0];
      // requester drops req and scribbles its operands; the latched copy must not move
      if (order[k] == 1) begin
        bus.req1 = 1'b0;
        bus.a1   = W'($urandom);
        bus.b1   = W'($urandom);
      end else begin
        bus.req0 = 1'b0;
        bus.a0   = W'($urandom);
        bus.b0   = W'($urandom);
      end
      @(negedge clk);
      chk("gnt_pulse", 64'(bus.gnt0 | bus.gnt1), 64'(0));
      chk("start_pulse", 64'(bus.mult_start), 64'(0));
      chk("busy_op", 64'(bus.busy), 64'(1));
      eerr = stuck_i || (lat_i + 2 > TIMEOUT);
      off  = eerr ? TIMEOUT : lat_i + 2;
      eres = eerr ? '0 : (2*W)'(ea) * (2*W)'(eb);
      wait_done(dwho, dat);
      chk("done_who", 64'(dwho), 64'(order[k]));
      chk("done_cyc", 64'(dat), 64'(at + off));
      chk("result", 64'(bus.result), 64'(eres));
      chk("err", 64'(bus.err), 64'(eerr));
      chk("busy_done", 64'(bus.busy), 64'(1));
      chk("hold_mult_a", 64'(bus.mult_a), 64'(ea));
      chk("hold_mult_b", 64'(bus.mult_b), 64'(eb));
      @(negedge clk);
      chk("done_pulse", 64'(bus.done0 | bus.done1), 64'(0));
      chk("err_pulse", 64'(bus.err), 64'(0));
      chk("result_hold", 64'(bus.result), 64'(eres));
      chk("busy_idle", 64'(bus.busy), 64'(0));
      prev = dat;
    end
  endtask

  initial begin
    int who;
    int at;
    int ndone;
    int p;
    rst      = 1'b0;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.a0   = '0;
    bus.b0   = '0;
    bus.a1   = '0;
    bus.b1   = '0;
    repeat (3) @(negedge clk);
    chk_rst_vals();
    rst = 1'b1;

    // first tie after reset goes to requester 0
    bus.a0 = 24'd5;
    bus.b0 = 24'd12;
    bus.a1 = 24'd3;
    bus.b1 = 24'd7;
    do_round(1'b1, 1'b1, 6, 1'b0);

    bus.a0 = 24'd2;
    bus.b0 = 24'd2;
    do_round(1'b1, 1'b0, 24, 1'b0);

    bus.a1 = 24'hFFFFFF;
    bus.b1 = 24'hFFFFFF;
    do_round(1'b0, 1'b1, 5, 1'b0);
    chk("max_product", 64'(bus.result), 64'(48'hFFFFFE000001));

    // four back-to-back operations with both requests held
    do_round(1'b1, 1'b1, 3, 1'b0);
    do_round(1'b1, 1'b1, 9, 1'b0);

    // stuck-ready abort, and the completion/timeout boundary
    do_round(1'b1, 1'b0, 1, 1'b1);
    do_round(1'b0, 1'b1, TIMEOUT - 2, 1'b0);
    do_round(1'b1, 1'b0, TIMEOUT - 1, 1'b0);

    // reset while waiting on the multiplier
    wait_mult_idle();
    bus.a0 = 24'd7;
    bus.b0 = 24'd9;
    @(negedge clk);
    lat      = 60;
    stuck    = 1'b0;
    bus.req0 = 1'b1;
    wait_gnt(who, at);
    chk("abort_gnt", 64'(who), 64'(0));
    bus.req0 = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_rst_vals();
    rst     = 1'b1;
    rr_last = 1'b1;
    ndone   = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (bus.done0 || bus.done1) ndone++;
    end
    chk("abort_no_done", 64'(ndone), 64'(0));
    chk("abort_idle", 64'(bus.busy), 64'(0));
    bus.a0 = 24'd11;
    bus.b0 = 24'd13;
    bus.a1 = 24'd17;
    bus.b1 = 24'd19;
    do_round(1'b1, 1'b1, 4, 1'b0);

    for (int i = 0; i < 14; i++) begin
      p      = $urandom_range(1, 3);
      bus.a0 = W'($urandom);
      bus.b0 = W'($urandom);
      bus.a1 = W'($urandom);
      bus.b1 = W'($urandom);
      do_round(p[0], p[1], $urandom_range(1, 30), ($urandom_range(0, 7) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
